// File: rtl/kbd_pkg.sv
// Shared scancodes, direction/command indices and small helpers for the PS/2 key-event decoder.
package kbd_pkg;

    localparam int unsigned NUM_DIRS = 4;
    localparam int unsigned DIR_W    = 2;
    localparam int unsigned NUM_CMDS = 5;
    localparam int unsigned CMD_W    = 3;

    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_SPDUP = 8'h41;
    localparam logic [7:0] SC_SPDDN = 8'h49;
    localparam logic [7:0] SC_PAUSE = 8'h44;
    localparam logic [7:0] SC_CLEAR = 8'h66;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    localparam logic [DIR_W-1:0] DIR_L = 2'd0;
    localparam logic [DIR_W-1:0] DIR_R = 2'd1;
    localparam logic [DIR_W-1:0] DIR_U = 2'd2;
    localparam logic [DIR_W-1:0] DIR_D = 2'd3;

    localparam logic [CMD_W-1:0] CMD_SPDUP = 3'd0;
    localparam logic [CMD_W-1:0] CMD_SPDDN = 3'd1;
    localparam logic [CMD_W-1:0] CMD_PAUSE = 3'd2;
    localparam logic [CMD_W-1:0] CMD_CLEAR = 3'd3;
    localparam logic [CMD_W-1:0] CMD_ENTER = 3'd4;

    // Left/right and up/down pairs differ only in bit 0.
    function automatic logic [DIR_W-1:0] opposite(input logic [DIR_W-1:0] d);
        return {d[1], ~d[0]};
    endfunction

    function automatic logic [NUM_DIRS-1:0] onehot(input logic [DIR_W-1:0] d);
        return 4'b0001 << d;
    endfunction

endpackage

// File: rtl/kbd_dir_tracker.sv
// Per-player direction state: held mask, last-pressed direction with release fallback,
// and the tick-sampled one-hot direction output.
module kbd_dir_tracker
    import kbd_pkg::*;
#(
    parameter int unsigned INIT_DIR      = 0,
    parameter bit          REVERSE_BLOCK = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                make,
    input  logic                brk,
    input  logic [DIR_W-1:0]    idx,
    input  logic                tick,
    output logic [NUM_DIRS-1:0] dir_out,
    output logic [NUM_DIRS-1:0] dir_held
);

    logic [NUM_DIRS-1:0] held_q, held_d;
    logic [NUM_DIRS-1:0] dir_oh_q, dir_oh_d;
    logic [DIR_W-1:0]    latest_q, latest_d;
    logic [DIR_W-1:0]    dir_q, dir_d;
    logic                found;

    always_comb begin
        held_d   = held_q;
        latest_d = latest_q;
        dir_d    = dir_q;
        found    = 1'b0;

        // Tick samples the pre-event latest; a same-cycle event shows up on the next tick.
        if (tick) begin
            dir_d = latest_q;
        end

        if (make) begin
            held_d[idx] = 1'b1;
            if (!(REVERSE_BLOCK && (idx == opposite(dir_q)))) begin
                latest_d = idx;
            end
        end else if (brk) begin
            held_d[idx] = 1'b0;
            // Releasing the active key falls back to the lowest eligible held key, else sticks.
            if (latest_q == idx) begin
                for (int unsigned i = 0; i < NUM_DIRS; i++) begin
                    if (!found && held_q[i] && (DIR_W'(i) != idx) &&
                        !(REVERSE_BLOCK && (DIR_W'(i) == opposite(dir_q)))) begin
                        latest_d = DIR_W'(i);
                        found    = 1'b1;
                    end
                end
            end
        end

        dir_oh_d = onehot(dir_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q   <= '0;
            latest_q <= DIR_W'(INIT_DIR);
            dir_q    <= DIR_W'(INIT_DIR);
            dir_oh_q <= onehot(DIR_W'(INIT_DIR));
        end else begin
            held_q   <= held_d;
            latest_q <= latest_d;
            dir_q    <= dir_d;
            dir_oh_q <= dir_oh_d;
        end
    end

    assign dir_out  = dir_oh_q;
    assign dir_held = held_q;

endmodule

// File: rtl/kbd_cmd_decoder.sv
// PS/2 key-event decoder: routes direction keys to per-player trackers and turns
// command keys into filtered pulses and levels.
module kbd_cmd_decoder
    import kbd_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS   = 2,
    parameter int unsigned INIT_DIR      = 0,
    parameter bit          REVERSE_BLOCK = 1'b1,
    parameter bit          REPEAT_FILTER = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [9:0]                      data,
    input  logic                            data_valid,
    input  logic                            tick,
    input  logic                            start_clr,
    output logic [NUM_DIRS*NUM_PLAYERS-1:0] dir_out,
    output logic [NUM_DIRS*NUM_PLAYERS-1:0] dir_held,
    output logic                            speed_up,
    output logic                            speed_down,
    output logic                            pause,
    output logic                            clear,
    output logic                            start
);

    logic             ev_ext;
    logic             ev_brk;
    logic [7:0]       ev_code;
    logic             dir_hit;
    logic             pl_sel;
    logic [DIR_W-1:0] dir_idx;
    logic             cmd_hit;
    logic [CMD_W-1:0] cmd_idx;

    assign ev_ext  = data[9];
    assign ev_brk  = data[8];
    assign ev_code = data[7:0];

    // Keymap decode; extended arrows belong to player 1, everything else needs ext=0.
    always_comb begin
        dir_hit = 1'b0;
        dir_idx = DIR_L;
        cmd_hit = 1'b0;
        cmd_idx = CMD_SPDUP;
        pl_sel  = ev_ext && (NUM_PLAYERS > 1);
        if (!ev_ext) begin
            case (ev_code)
                SC_A:     begin dir_hit = 1'b1; dir_idx = DIR_L;     end
                SC_D:     begin dir_hit = 1'b1; dir_idx = DIR_R;     end
                SC_W:     begin dir_hit = 1'b1; dir_idx = DIR_U;     end
                SC_S:     begin dir_hit = 1'b1; dir_idx = DIR_D;     end
                SC_SPDUP: begin cmd_hit = 1'b1; cmd_idx = CMD_SPDUP; end
                SC_SPDDN: begin cmd_hit = 1'b1; cmd_idx = CMD_SPDDN; end
                SC_PAUSE: begin cmd_hit = 1'b1; cmd_idx = CMD_PAUSE; end
                SC_CLEAR: begin cmd_hit = 1'b1; cmd_idx = CMD_CLEAR; end
                SC_ENTER: begin cmd_hit = 1'b1; cmd_idx = CMD_ENTER; end
                default:  ;
            endcase
        end else begin
            case (ev_code)
                SC_LEFT:  begin dir_hit = 1'b1; dir_idx = DIR_L; end
                SC_RIGHT: begin dir_hit = 1'b1; dir_idx = DIR_R; end
                SC_UP:    begin dir_hit = 1'b1; dir_idx = DIR_U; end
                SC_DOWN:  begin dir_hit = 1'b1; dir_idx = DIR_D; end
                default:  ;
            endcase
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [NUM_DIRS-1:0] held_p;
        logic                sel_p;
        logic                mk_p;
        logic                brk_p;

        assign held_p = dir_held[NUM_DIRS*p +: NUM_DIRS];
        assign sel_p  = data_valid && dir_hit && (pl_sel == 1'(p));
        assign mk_p   = sel_p && !ev_brk && !(REPEAT_FILTER && held_p[dir_idx]);
        assign brk_p  = sel_p && ev_brk;

        kbd_dir_tracker #(
            .INIT_DIR      (INIT_DIR),
            .REVERSE_BLOCK (REVERSE_BLOCK)
        ) u_trk (
            .clk      (clk),
            .rst_n    (rst_n),
            .make     (mk_p),
            .brk      (brk_p),
            .idx      (dir_idx),
            .tick     (tick),
            .dir_out  (dir_out[NUM_DIRS*p +: NUM_DIRS]),
            .dir_held (dir_held[NUM_DIRS*p +: NUM_DIRS])
        );
    end

    logic [NUM_CMDS-1:0] cmd_held_q, cmd_held_d;
    logic                speed_up_q, speed_up_d;
    logic                speed_down_q, speed_down_d;
    logic                pause_q, pause_d;
    logic                start_q, start_d;

    // Command keys track their own held bit so typematic repeats are swallowed.
    always_comb begin
        cmd_held_d   = cmd_held_q;
        speed_up_d   = 1'b0;
        speed_down_d = 1'b0;
        pause_d      = pause_q;
        start_d      = start_q && !start_clr;
        if (data_valid && cmd_hit) begin
            if (ev_brk) begin
                cmd_held_d[cmd_idx] = 1'b0;
            end else begin
                cmd_held_d[cmd_idx] = 1'b1;
                if (!(REPEAT_FILTER && cmd_held_q[cmd_idx])) begin
                    case (cmd_idx)
                        CMD_SPDUP: speed_up_d   = 1'b1;
                        CMD_SPDDN: speed_down_d = 1'b1;
                        CMD_PAUSE: pause_d      = !pause_q;
                        CMD_ENTER: start_d      = 1'b1;
                        default:   ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_held_q   <= '0;
            speed_up_q   <= 1'b0;
            speed_down_q <= 1'b0;
            pause_q      <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            cmd_held_q   <= cmd_held_d;
            speed_up_q   <= speed_up_d;
            speed_down_q <= speed_down_d;
            pause_q      <= pause_d;
            start_q      <= start_d;
        end
    end

    assign speed_up   = speed_up_q;
    assign speed_down = speed_down_q;
    assign pause      = pause_q;
    assign clear      = cmd_held_q[CMD_CLEAR];
    assign start      = start_q;

endmodule

// File: tb/tb_kbd_cmd_decoder.sv
// Bench for kbd_cmd_decoder: directed vector table, async reset mid-hold, and random
// events against a key-table reference model.
module tb_kbd_cmd_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] data;
    logic       data_valid;
    logic       tick;
    logic       start_clr;
    logic [7:0] dir_out;
    logic [7:0] dir_held;
    logic       speed_up, speed_down, pause, clear, start;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    kbd_cmd_decoder #(
        .NUM_PLAYERS   (2),
        .INIT_DIR      (0),
        .REVERSE_BLOCK (1'b1),
        .REPEAT_FILTER (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .data_valid (data_valid),
        .tick       (tick),
        .start_clr  (start_clr),
        .dir_out    (dir_out),
        .dir_held   (dir_held),
        .speed_up   (speed_up),
        .speed_down (speed_down),
        .pause      (pause),
        .clear      (clear),
        .start      (start)
    );

    // Reference model: a table of every key's held state plus per-player direction state.
    logic [7:0] dcodes [2][4] = '{'{8'h1C, 8'h23, 8'h1D, 8'h1B}, '{8'h6B, 8'h74, 8'h75, 8'h72}};
    bit kh [2][256];
    int m_latest [2];
    int m_dout [2];
    bit m_su, m_sd, m_pause, m_start;

    function void model_reset();
        foreach (kh[e, c]) kh[e][c] = 1'b0;
        m_latest = '{0, 0};
        m_dout   = '{0, 0};
        m_su = 0; m_sd = 0; m_pause = 0; m_start = 0;
    endfunction

    function void model_step(input bit v, input logic [9:0] d, input bit tk, input bit sc);
        int   pre_latest [2];
        int   p, dd;
        bit   isdir, already, ext, brk, found;
        logic [7:0] code;
        pre_latest = m_latest;
        m_su = 0;
        m_sd = 0;
        if (sc) m_start = 0;
        if (v) begin
            ext   = d[9];
            brk   = d[8];
            code  = d[7:0];
            isdir = 0;
            p     = ext ? 1 : 0;
            dd    = 0;
            for (int k = 0; k < 4; k++)
                if (code == dcodes[p][k]) begin isdir = 1; dd = k; end
            already = kh[p][code];
            kh[p][code] = !brk;
            if (isdir) begin
                if (brk) begin
                    if (m_latest[p] == dd) begin
                        found = 0;
                        for (int i = 0; i < 4; i++)
                            if (!found && i != dd && kh[p][dcodes[p][i]] && i != (m_dout[p] ^ 1)) begin
                                m_latest[p] = i;
                                found = 1;
                            end
                    end
                end else if (!already && dd != (m_dout[p] ^ 1)) begin
                    m_latest[p] = dd;
                end
            end else if (!ext && !brk && !already) begin
                case (code)
                    8'h41: m_su = 1;
                    8'h49: m_sd = 1;
                    8'h44: m_pause = !m_pause;
                    8'h5A: m_start = 1;
                    default: ;
                endcase
            end
        end
        if (tk) m_dout = pre_latest;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic apply(input bit v, input logic [9:0] d, input bit tk, input bit sc);
        data_valid = v;
        data       = d;
        tick       = tk;
        start_clr  = sc;
        model_step(v, d, tk, sc);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        tick       = 1'b0;
        start_clr  = 1'b0;
    endtask

    task automatic check_model(input string tag);
        logic [7:0] e_dout, e_held;
        for (int p = 0; p < 2; p++) begin
            e_dout[p*4 +: 4] = 4'b0001 << m_dout[p];
            for (int i = 0; i < 4; i++) e_held[p*4 + i] = kh[p][dcodes[p][i]];
        end
        chk({tag, "_dir_out"},  dir_out, e_dout);
        chk({tag, "_dir_held"}, dir_held, e_held);
        chk({tag, "_speed_up"}, speed_up, m_su);
        chk({tag, "_speed_dn"}, speed_down, m_sd);
        chk({tag, "_pause"},    pause, m_pause);
        chk({tag, "_clear"},    clear, kh[0][8'h66]);
        chk({tag, "_start"},    start, m_start);
    endtask

    typedef struct {
        bit         v;
        logic [9:0] d;
        bit         tk;
        bit         sc;
        logic [7:0] dout;
        logic [7:0] held;
        logic [4:0] fl;   // {speed_up, speed_down, pause, clear, start}
    } vec_t;

    function automatic vec_t vec(bit v, logic [9:0] d, bit tk, bit sc,
                                 logic [7:0] dout, logic [7:0] held, logic [4:0] fl);
        vec_t r;
        r.v = v; r.d = d; r.tk = tk; r.sc = sc; r.dout = dout; r.held = held; r.fl = fl;
        return r;
    endfunction

    logic [8:0] pool [15] = '{9'h01C, 9'h023, 9'h01D, 9'h01B, 9'h16B, 9'h174, 9'h175, 9'h172,
                              9'h041, 9'h049, 9'h044, 9'h066, 9'h05A, 9'h06B, 9'h15A};

    initial begin
        vec_t tbl [$];
        logic [8:0] pk;
        logic [7:0] code;
        bit v, brk, tk, sc;

        rst_n = 1'b0; data = '0; data_valid = 1'b0; tick = 1'b0; start_clr = 1'b0;
        model_reset();
        #22;
        rst_n = 1'b1;
        chk("rst_dir_out", dir_out, 8'h11);
        chk("rst_dir_held", dir_held, 8'h00);
        chk("rst_cmds", {speed_up, speed_down, pause, clear, start}, 5'b0);

        tbl.push_back(vec(0, 10'h000, 1, 0, 8'h11, 8'h00, 5'b00000));
        tbl.push_back(vec(1, 10'h01D, 0, 0, 8'h11, 8'h04, 5'b00000));
        tbl.push_back(vec(0, 10'h000, 1, 0, 8'h14, 8'h04, 5'b00000));
        tbl.push_back(vec(1, 10'h01B, 0, 0, 8'h14, 8'h0C, 5'b00000));
        tbl.push_back(vec(0, 10'h000, 1, 0, 8'h14, 8'h0C, 5'b00000));
        tbl.push_back(vec(1, 10'h11B, 0, 0, 8'h14, 8'h04, 5'b00000));
        tbl.push_back(vec(1, 10'h023, 0, 0, 8'h14, 8'h06, 5'b00000));
        tbl.push_back(vec(0, 10'h000, 1, 0, 8'h12, 8'h06, 5'b00000));
        tbl.push_back(vec(1, 10'h123, 0, 0, 8'h12, 8'h04, 5'b00000));
        tbl.push_back(vec(0, 10'h000, 1, 0, 8'h14, 8'h04, 5'b00000));
        tbl.push_back(vec(1, 10'h11D, 0, 0, 8'h14, 8'h00, 5'b00000));
        tbl.push_back(vec(0, 10'h000, 1, 0, 8'h14, 8'h00, 5'b00000));
        tbl.push_back(vec(1, 10'h06B, 1, 0, 8'h14, 8'h00, 5'b00000));
        tbl.push_back(vec(1, 10'h26B, 1, 0, 8'h14, 8'h10, 5'b00000));
        tbl.push_back(vec(1, 10'h274, 0, 0, 8'h14, 8'h30, 5'b00000));
        tbl.push_back(vec(0, 10'h000, 1, 0, 8'h14, 8'h30, 5'b00000));
        tbl.push_back(vec(1, 10'h275, 0, 0, 8'h14, 8'h70, 5'b00000));
        tbl.push_back(vec(0, 10'h000, 1, 0, 8'h44, 8'h70, 5'b00000));
        tbl.push_back(vec(1, 10'h375, 1, 0, 8'h44, 8'h30, 5'b00000));
        tbl.push_back(vec(0, 10'h000, 1, 0, 8'h14, 8'h30, 5'b00000));
        tbl.push_back(vec(1, 10'h041, 0, 0, 8'h14, 8'h30, 5'b10000));
        for (int i = 0; i < 4; i++)
            tbl.push_back(vec(1, 10'h041, 0, 0, 8'h14, 8'h30, 5'b00000));
        tbl.push_back(vec(1, 10'h141, 0, 0, 8'h14, 8'h30, 5'b00000));
        tbl.push_back(vec(1, 10'h041, 0, 0, 8'h14, 8'h30, 5'b10000));
        tbl.push_back(vec(0, 10'h000, 0, 0, 8'h14, 8'h30, 5'b00000));
        tbl.push_back(vec(1, 10'h049, 0, 0, 8'h14, 8'h30, 5'b01000));
        tbl.push_back(vec(1, 10'h044, 0, 0, 8'h14, 8'h30, 5'b00100));
        tbl.push_back(vec(1, 10'h044, 0, 0, 8'h14, 8'h30, 5'b00100));
        tbl.push_back(vec(1, 10'h144, 0, 0, 8'h14, 8'h30, 5'b00100));
        tbl.push_back(vec(1, 10'h044, 0, 0, 8'h14, 8'h30, 5'b00000));
        tbl.push_back(vec(1, 10'h066, 0, 0, 8'h14, 8'h30, 5'b00010));
        tbl.push_back(vec(1, 10'h166, 0, 0, 8'h14, 8'h30, 5'b00000));
        tbl.push_back(vec(1, 10'h05A, 0, 1, 8'h14, 8'h30, 5'b00001));
        tbl.push_back(vec(1, 10'h15A, 0, 0, 8'h14, 8'h30, 5'b00001));
        tbl.push_back(vec(0, 10'h000, 0, 1, 8'h14, 8'h30, 5'b00000));
        tbl.push_back(vec(1, 10'h25A, 0, 0, 8'h14, 8'h30, 5'b00000));
        tbl.push_back(vec(1, 10'h05A, 0, 0, 8'h14, 8'h30, 5'b00001));
        tbl.push_back(vec(1, 10'h0AA, 0, 0, 8'h14, 8'h30, 5'b00001));

        foreach (tbl[i]) begin
            apply(tbl[i].v, tbl[i].d, tbl[i].tk, tbl[i].sc);
            chk($sformatf("tbl%0d_dir_out", i), dir_out, tbl[i].dout);
            chk($sformatf("tbl%0d_dir_held", i), dir_held, tbl[i].held);
            chk($sformatf("tbl%0d_cmds", i), {speed_up, speed_down, pause, clear, start}, tbl[i].fl);
        end

        // Async reset while clear and W are held; the later breaks must be harmless.
        apply(1, 10'h066, 0, 0);
        apply(1, 10'h01D, 0, 0);
        check_model("hold");
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_clear", clear, 1'b0);
        chk("midrst_start", start, 1'b0);
        chk("midrst_dir_held", dir_held, 8'h00);
        chk("midrst_dir_out", dir_out, 8'h11);
        model_reset();
        #2 rst_n = 1'b1;
        apply(1, 10'h166, 0, 0);
        check_model("postrst_brk_clear");
        apply(1, 10'h11D, 1, 0);
        check_model("postrst_brk_w");

        for (int n = 0; n < 3000; n++) begin
            v   = ($urandom_range(0, 9) < 7);
            pk  = pool[$urandom_range(0, 14)];
            brk = $urandom_range(0, 1) == 1;
            code = pk[7:0];
            if ($urandom_range(0, 15) == 0) code = 8'($urandom);
            tk  = ($urandom_range(0, 3) == 0);
            sc  = ($urandom_range(0, 9) == 0);
            apply(v, {pk[8], brk, code}, tk, sc);
            check_model("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
